// File: rtl/aes_pkg.sv
// aes_pkg: shared constants and the serializer FSM state encoding used by the
// AES-256 output stage (block FIFO and ciphertext serializer).
package aes_pkg;

  localparam int AES_BLK_W    = 128; // ciphertext block width
  localparam int AES_WORD_W   = 32;  // output word width
  localparam int AES_PIPE_LAT = 14;  // pipeline latency, input sample to ct sample

  localparam int AES_WORDS_PER_BLK = AES_BLK_W / AES_WORD_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/aes_blk_fifo.sv
// aes_blk_fifo: synchronous block FIFO, W bits wide, DEPTH entries.
//   clk, rst : clock, synchronous active-high reset (pointers and level only)
//   wr_en    : push wr_data (ignored when full unless rd_en pops on the same edge)
//   rd_en    : pop; rd_data is the head entry, sampled by the consumer on the pop edge
//   full, empty, level : occupancy status
// The storage is a register array, so rd_data is a registered value selected by
// the read pointer. A push and a pop on the same edge while full is legal: the
// head is read out before the write lands in the slot it frees.
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = AES_BLK_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wptr_q, rptr_q;
  logic [AW:0]             level_q, level_d;
  logic                    do_wr, do_rd;

  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign level = level_q;

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_comb begin
    level_d = level_q;
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Data storage carries no reset; only the bookkeeping does.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + AW'(1);
      if (do_rd) rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  assign rd_data = mem_q[rptr_q];

endmodule

// File: rtl/aes_ct_serializer.sv
// aes_ct_serializer: output stage behind the AES-256 round pipeline.
//   clk, rst      : shared clock, synchronous active-high reset
//   blk_valid_in  : real block presented at the pipeline input this cycle
//   in_ready      : credit to upstream (blocks in flight + buffered < DEPTH)
//   ct_in         : pipeline ciphertext, sampled PIPE_LAT edges after its tag
//   out_valid/out_ready/out_data/out_last : 32-bit word stream, MS word first
//   overflow      : sticky, a captured block was dropped
//   fifo_level    : blocks held in the FIFO (not counting the one being sent)
// The pipeline cannot stall, so a valid tag travels alongside it (vpipe) and
// decides which ct_in samples are real. Credit counts tags still in the pipe
// plus buffered blocks so a well-behaved upstream can never overrun the FIFO.
module aes_ct_serializer
  import aes_pkg::*;
#(
  parameter int PIPE_LAT = AES_PIPE_LAT, // must be >= 2
  parameter int DEPTH    = 4             // power of two, >= 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       blk_valid_in,
  output logic                       in_ready,
  input  logic [AES_BLK_W-1:0]       ct_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [AES_WORD_W-1:0]      out_data,
  output logic                       out_last,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int LW  = $clog2(DEPTH) + 1;
  localparam int IFW = $clog2(PIPE_LAT + 1);

  // ---------------------------------------------------------------------------
  // Valid tag pipe and in-flight count
  // ---------------------------------------------------------------------------
  logic [PIPE_LAT-1:0] vpipe_q, vpipe_d;
  logic [IFW-1:0]      inflight_q, inflight_d;
  logic                cap;

  assign cap     = vpipe_q[PIPE_LAT-1];
  assign vpipe_d = {vpipe_q[PIPE_LAT-2:0], blk_valid_in};

  // Running popcount of vpipe: one enters, one leaves, or both (no change).
  always_comb begin
    inflight_d = inflight_q;
    case ({blk_valid_in, cap})
      2'b10:   inflight_d = inflight_q + IFW'(1);
      2'b01:   inflight_d = inflight_q - IFW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe_q    <= '0;
      inflight_q <= '0;
    end else begin
      vpipe_q    <= vpipe_d;
      inflight_q <= inflight_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Block FIFO
  // ---------------------------------------------------------------------------
  logic                 fifo_full, fifo_empty;
  logic [LW-1:0]        fifo_lvl;
  logic [AES_BLK_W-1:0] fifo_rd_data;
  logic                 pop, push, drop;

  aes_blk_fifo #(
    .DEPTH (DEPTH),
    .W     (AES_BLK_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (ct_in),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_lvl)
  );

  assign fifo_level = fifo_lvl;

  // Purely register-based; no same-cycle input reaches the credit.
  logic [31:0] credit_used;
  assign credit_used = 32'(inflight_q) + 32'(fifo_lvl);
  assign in_ready    = (credit_used < 32'(DEPTH));

  // ---------------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------------
  ser_state_e           state_q;
  logic [1:0]           beat_q;
  logic [AES_BLK_W-1:0] sh_q;
  logic                 ovf_q;
  logic                 hs, blk_done;

  assign hs       = (state_q == ST_SEND) && out_ready;
  assign blk_done = hs && (beat_q == 2'd3);

  // Reload straight from the FIFO on the last beat so blocks stream with no gap.
  assign pop  = !fifo_empty && ((state_q == ST_IDLE) || blk_done);
  // A full FIFO still accepts the capture if the same edge frees a slot.
  assign push = cap && (!fifo_full || pop);
  assign drop = cap && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= 2'd0;
      sh_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (drop) ovf_q <= 1'b1;
      if (pop) begin
        sh_q    <= fifo_rd_data;
        beat_q  <= 2'd0;
        state_q <= ST_SEND;
      end else if (hs) begin
        // After the 4th shift sh_q is all zeros, so out_data idles at 0.
        sh_q   <= {sh_q[AES_BLK_W-AES_WORD_W-1:0], {AES_WORD_W{1'b0}}};
        beat_q <= beat_q + 2'd1;
        if (blk_done) state_q <= ST_IDLE;
      end
    end
  end

  assign out_valid = (state_q == ST_SEND);
  assign out_last  = (state_q == ST_SEND) && (beat_q == 2'd3);
  assign out_data  = sh_q[AES_BLK_W-1 -: AES_WORD_W];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_aes_ct_serializer.sv
module tb_aes_ct_serializer;
  import aes_pkg::*;

  localparam int PL    = 14;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         blk_valid_in = 1'b0;
  logic         in_ready;
  logic [127:0] ct_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic         out_last;
  logic         overflow;
  logic [2:0]   fifo_level;

  always #5 clk = ~clk;

  aes_ct_serializer #(.PIPE_LAT(PL), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .blk_valid_in (blk_valid_in),
    .in_ready     (in_ready),
    .ct_in        (ct_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .overflow     (overflow),
    .fifo_level   (fifo_level)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tag/data delay line, block queue, one block being sent.
  // ---------------------------------------------------------------------------
  bit           vh[$];   // tags of the last PL edges, oldest first
  logic [127:0] dh[$];   // data the bench will present with each tag
  logic [127:0] mq[$];   // buffered blocks
  logic [127:0] cur;
  int           beat;
  bit           act;
  bit           ovf;
  logic [31:0]  words[$]; // words the DUT handed over

  task automatic m_reset();
    vh.delete(); dh.delete(); mq.delete();
    for (int i = 0; i < PL; i++) begin vh.push_back(1'b0); dh.push_back('0); end
    act = 0; beat = 0; ovf = 0; cur = '0;
  endtask

  function automatic int m_infl();
    int n = 0;
    foreach (vh[i]) n += vh[i];
    return n;
  endfunction

  function automatic bit m_rdy();
    return (m_infl() + mq.size()) < DEPTH;
  endfunction

  task automatic m_edge(input bit v, input bit rdy, input bit r, input logic [127:0] d,
                        input logic [127:0] bus);
    bit cap, fin, can;
    if (r) begin
      m_reset();
      return;
    end
    cap = vh[0];
    fin = act && rdy && (beat == 3);
    can = !act || fin;
    if (act && rdy) beat++;
    if (fin) act = 0;
    if (can && mq.size() > 0) begin
      cur  = mq.pop_front();
      beat = 0;
      act  = 1;
    end
    if (cap) begin
      if (mq.size() == DEPTH) ovf = 1;
      else mq.push_back(bus);
    end
    void'(vh.pop_front()); void'(dh.pop_front());
    vh.push_back(v); dh.push_back(d);
  endtask

  // One clock: drive, edge, model, sample and compare 1 time unit later.
  task automatic tick(input bit v, input bit rdy, input bit r, input logic [127:0] d);
    logic [127:0] bus;
    blk_valid_in = v;
    out_ready    = rdy;
    rst          = r;
    bus = vh[0] ? dh[0] : {$urandom, $urandom, $urandom, $urandom};
    ct_in = bus;
    if (out_valid && rdy && !r) words.push_back(out_data);
    @(posedge clk);
    m_edge(v, rdy, r, d, bus);
    #1;
    chk("out_valid",  {31'd0, out_valid}, {31'd0, act});
    chk("out_data",   out_data, act ? cur[127 - 32*beat -: 32] : 32'd0);
    chk("out_last",   {31'd0, out_last}, {31'd0, act && beat == 3});
    chk("fifo_level", {29'd0, fifo_level}, 32'(mq.size()));
    chk("in_ready",   {31'd0, in_ready}, {31'd0, m_rdy()});
    chk("overflow",   {31'd0, overflow}, {31'd0, ovf});
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [31:0] exp_w[4];

  initial begin
    m_reset();

    // Reset state
    repeat (3) tick(0, 1, 1, '0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  out_data, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst_level",     {29'd0, fifo_level}, 32'd0);

    // Single block with a known ciphertext
    repeat (2) tick(0, 1, 0, '0);
    words.delete();
    tick(1, 1, 0, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    repeat (PL + 8) tick(0, 1, 0, '0);
    exp_w = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    chk("single_nwords", 32'(words.size()), 32'd4);
    for (int i = 0; i < 4 && i < words.size(); i++) chk("single_word", words[i], exp_w[i]);

    // Back-to-back: credit closes after the 4th tag
    words.delete();
    for (int i = 0; i < 4; i++) tick(1, 1, 0, rnd128());
    chk("b2b_in_ready_low", {31'd0, in_ready}, 32'd0);
    repeat (PL + 20) tick(0, 1, 0, '0);
    chk("b2b_nwords", 32'(words.size()), 32'd16);
    chk("b2b_overflow", {31'd0, overflow}, 32'd0);

    // Backpressure: out_ready 1,0,0,1,0,0,...
    words.delete();
    tick(1, 1, 0, rnd128());
    for (int p = 0; p < PL + 20; p++) tick(0, (p % 3) == 0, 0, '0);
    chk("bp_nwords", 32'(words.size()), 32'd4);
    chk("bp_level", {29'd0, fifo_level}, 32'd0);

    // Full FIFO: capture and pop land on the same edge
    for (int i = 0; i < 5; i++) tick(1, 0, 0, rnd128()); // one sits in the serializer
    repeat (PL + 2) tick(0, 0, 0, '0);
    chk("full_level", {29'd0, fifo_level}, 32'd4);
    tick(1, 0, 0, rnd128());                  // captured 14 edges later
    repeat (PL - 4) tick(0, 0, 0, '0);
    repeat (4) tick(0, 1, 0, '0);             // 4th handshake coincides with capture
    chk("same_edge_level", {29'd0, fifo_level}, 32'd4);
    chk("same_edge_ovf",   {31'd0, overflow}, 32'd0);
    repeat (30) tick(0, 1, 0, '0);

    // Overflow: serializer stalled holds one block and the FIFO four more,
    // so the 6th block issued against no credit is the one dropped.
    tick(0, 0, 1, '0);
    words.delete();
    for (int i = 0; i < 6; i++) tick(1, 0, 0, rnd128());
    repeat (PL + 2) tick(0, 0, 0, '0);
    chk("ovf_level", {29'd0, fifo_level}, 32'd4);
    chk("ovf_flag",  {31'd0, overflow}, 32'd1);
    repeat (30) tick(0, 1, 0, '0);
    chk("ovf_nwords", 32'(words.size()), 32'd20);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset mid-stream: 1 sending, 2 queued, 1 in flight
    tick(0, 0, 1, '0);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, rnd128());
    repeat (5) tick(0, 0, 0, '0);
    tick(1, 0, 0, rnd128());
    repeat (PL - 6) tick(0, 0, 0, '0);
    chk("mid_level_before", {29'd0, fifo_level}, 32'd2);
    repeat (2) tick(0, 1, 0, '0);
    tick(0, 1, 1, '0);
    chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_level",     {29'd0, fifo_level}, 32'd0);
    chk("mid_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("mid_overflow",  {31'd0, overflow}, 32'd0);
    repeat (PL) tick(0, 1, 0, '0);
    chk("mid_late_level", {29'd0, fifo_level}, 32'd0);
    chk("mid_late_valid", {31'd0, out_valid}, 32'd0);

    // Random traffic respecting the credit, random backpressure
    for (int i = 0; i < 600; i++)
      tick(m_rdy() && ($urandom_range(0, 1) == 1), $urandom_range(0, 3) != 0, 0, rnd128());
    repeat (PL + 40) tick(0, 1, 0, '0);
    chk("rand_overflow", {31'd0, overflow}, 32'd0);
    chk("rand_drained",  {29'd0, fifo_level}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
